// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU operation codes, RV32I
// opcode/funct fields used by the decoder, and the decoded-operation bundle.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 32;

  // ALU operation codes; code 2 is reserved and never issued.
  typedef enum logic [OPW-1:0] {
    ALU_ADD  = 32'd0,
    ALU_SUB  = 32'd1,
    ALU_SLL  = 32'd3,
    ALU_SRL  = 32'd4,
    ALU_SRA  = 32'd5,
    ALU_SLTU = 32'd6,
    ALU_SLT  = 32'd7,
    ALU_OR   = 32'd8,
    ALU_AND  = 32'd9,
    ALU_XOR  = 32'd10,
    ALU_LUI  = 32'd11
  } alu_op_e;

  // RV32I major opcodes handled by this stage.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct3 encodings shared by register and immediate forms.
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7: base encoding and the alternate (SUB/SRA) encoding.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e          op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [4:0]       rd;
    logic             we;
    logic             illegal;
  } issue_bundle_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I integer-ALU decoder: instruction, PC and register
// operands in, ALU operation bundle out.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_bundle_t   bundle
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] shamt_r;
  logic [XLEN-1:0] shamt_i;
  logic            illegal_c;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign shamt_r = {27'b0, rs2_data[4:0]};
  assign shamt_i = {27'b0, instr[24:20]};

  // Decode the supported subset; anything else is flagged illegal and zeroed.
  always_comb begin
    // NOTE: every field gets a default up front so no path can infer a latch.
    bundle    = '0;
    illegal_c = 1'b0;
    bundle.rd = instr[11:7];

    if (instr[1:0] != 2'b11) begin
      illegal_c = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          bundle.a = rs1_data;
          bundle.b = rs2_data;
          if (!(funct7 == F7_BASE ||
                (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA))))
            illegal_c = 1'b1;
          case (funct3)
            F3_ADD_SUB: bundle.op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            F3_SLL: begin
              bundle.op = ALU_SLL;
              bundle.b  = shamt_r;
            end
            F3_SLT:     bundle.op = ALU_SLT;
            F3_SLTU:    bundle.op = ALU_SLTU;
            F3_XOR:     bundle.op = ALU_XOR;
            F3_SRL_SRA: begin
              bundle.op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
              bundle.b  = shamt_r;
            end
            F3_OR:      bundle.op = ALU_OR;
            default:    bundle.op = ALU_AND;  // F3_AND
          endcase
        end
        OPC_OP_IMM: begin
          bundle.a = rs1_data;
          bundle.b = imm_i;
          case (funct3)
            F3_ADD_SUB: bundle.op = ALU_ADD;
            F3_SLL: begin
              bundle.op = ALU_SLL;
              bundle.b  = shamt_i;
              if (funct7 != F7_BASE) illegal_c = 1'b1;
            end
            F3_SLT:     bundle.op = ALU_SLT;
            F3_SLTU:    bundle.op = ALU_SLTU;
            F3_XOR:     bundle.op = ALU_XOR;
            F3_SRL_SRA: begin
              bundle.op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
              bundle.b  = shamt_i;
              if (funct7 != F7_BASE && funct7 != F7_ALT) illegal_c = 1'b1;
            end
            F3_OR:      bundle.op = ALU_OR;
            default:    bundle.op = ALU_AND;  // F3_AND
          endcase
        end
        OPC_LUI: begin
          bundle.op = ALU_LUI;
          bundle.a  = {12'b0, instr[31:12]};
          bundle.b  = '0;
        end
        OPC_AUIPC: begin
          bundle.op = ALU_ADD;
          bundle.a  = pc;
          bundle.b  = {instr[31:12], 12'b0};
        end
        default: illegal_c = 1'b1;
      endcase
    end

    if (illegal_c) begin
      bundle.op = ALU_ADD;
      bundle.a  = '0;
      bundle.b  = '0;
    end
    bundle.illegal = illegal_c;
    bundle.we      = !illegal_c && (bundle.rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes one instruction per cycle and presents it through
// a registered valid/ready output backed by a one-entry skid buffer, so the
// upstream ready never depends combinationally on the downstream ready.
module alu_issue
  import alu_pkg::*;
#(
  parameter int WORDSIZE = 32,
  parameter int OPSIZE   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [WORDSIZE-1:0] pc,
  input  logic [WORDSIZE-1:0] rs1_data,
  input  logic [WORDSIZE-1:0] rs2_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPSIZE-1:0]   op,
  output logic [WORDSIZE-1:0] a,
  output logic [WORDSIZE-1:0] b,
  output logic [4:0]          rd,
  output logic                we,
  output logic                illegal
);

  issue_bundle_t dec;
  issue_bundle_t out_q;
  issue_bundle_t skid_q;
  logic          skid_valid;
  logic          in_fire;
  logic          out_load;

  alu_decode u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .bundle   (dec)
  );

  // Ready depends only on registered skid state, never on out_ready.
  assign in_ready = rst_n & ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_load = ~out_valid | out_ready;

  // Output register and skid occupancy: refill from skid first to keep order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
    end else if (out_load) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_q      <= dec;
        out_valid  <= 1'b1;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
    end
  end

  // Skid payload capture when the output is stalled.
  // NOTE: the skid payload has no reset; skid_valid alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (!out_load && in_fire) skid_q <= dec;
  end

  assign op      = OPSIZE'(out_q.op);
  assign a       = WORDSIZE'(out_q.a);
  assign b       = WORDSIZE'(out_q.b);
  assign rd      = out_q.rd;
  assign we      = out_q.we;
  assign illegal = out_q.illegal;

endmodule
